vec3_join: RTL and testbench
============================

VEC3_JOIN -- requirements
Module: vec3_join

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the signed width of each vector element.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-low reset sampled on the clock rising edge.
REQ-004 The block SHALL have port a[2:0], input, 3 x DATA_WIDTH signed, the head vector of first-word-fall-through FIFO A, valid while a_empty=0.
REQ-005 The block SHALL have port a_empty, input, 1, FIFO A empty flag.
REQ-006 The block SHALL have port a_rd_en, output, 1, pop strobe for FIFO A.
REQ-007 The block SHALL have port b[2:0], input, 3 x DATA_WIDTH signed, the head vector of first-word-fall-through FIFO B, valid while b_empty=0.
REQ-008 The block SHALL have port b_empty, input, 1, FIFO B empty flag.
REQ-009 The block SHALL have port b_rd_en, output, 1, pop strobe for FIFO B.
REQ-010 The block SHALL have port x[2:0], output, 3 x DATA_WIDTH signed, the A-half of the head joined pair.
REQ-011 The block SHALL have port y[2:0], output, 3 x DATA_WIDTH signed, the B-half of the head joined pair.
REQ-012 The block SHALL have port out_empty, output, 1, high when no joined pair is held.
REQ-013 The block SHALL have port out_rd_en, input, 1, downstream pop strobe for the head pair.

Function
REQ-014 The block SHALL hold joined pairs in a 2-entry in-order buffer, with state S_EMPTY (0 entries), S_ONE (1) or S_FULL (2).
REQ-015 a_rd_en and b_rd_en SHALL be identical and equal to reset high AND a_empty=0 AND b_empty=0 AND state!=S_FULL.
REQ-016 a_rd_en and b_rd_en SHALL NOT depend combinationally on out_rd_en.
REQ-017 One side SHALL never be popped without the other; A nonempty with B empty, or the reverse, SHALL produce no pop.
REQ-018 On a pop cycle the block SHALL capture a[2:0] and b[2:0] as one pair at that rising edge, bit-exact with no arithmetic.
REQ-019 A pair popped in cycle N SHALL appear on x/y with out_empty=0 in cycle N+1 if the buffer was empty; the latency is 1 cycle.
REQ-020 x[2:0], y[2:0] and out_empty SHALL be driven directly from registers.
REQ-021 x/y SHALL show the oldest held pair; x/y are don't-care while out_empty=1.
REQ-022 out_rd_en while out_empty=0 SHALL remove the head pair at the next edge; out_rd_en while out_empty=1 SHALL be ignored.
REQ-023 Transitions SHALL be: push only gives +1 state; pop only gives -1; push and pop together leave the state unchanged and keep order; neither leaves it unchanged.
REQ-024 In S_ONE with push and pop every cycle, sustained throughput SHALL be one pair per cycle.
REQ-025 Overflow and underflow SHALL be impossible; a push is never issued in S_FULL and a pop never takes effect in S_EMPTY.

Reset
REQ-026 While reset=0 at a rising edge, the block SHALL go to S_EMPTY, set out_empty=1 and set x[i]=y[i]=0, discarding held pairs.
REQ-027 While reset=0, a_rd_en and b_rd_en SHALL be 0 regardless of a_empty and b_empty.
REQ-028 Reset asserted mid-stream SHALL take effect at the next edge, with no partial pair retained or emitted.

Verification
REQ-029 Bench SHALL cover: reset=0 with a_empty=b_empty=0 -> a_rd_en=b_rd_en=0; after the edge out_empty=1, x=y=(0,0,0).
REQ-030 Bench SHALL cover: a=(1,2,3), b=(4,5,6), both nonempty for one cycle, out_rd_en=0 -> next cycle out_empty=0, x=(1,2,3), y=(4,5,6).
REQ-031 Bench SHALL cover: a_empty=0, b_empty=1 for 5 cycles -> no rd_en and out_empty stays 1; then b_empty=0 -> a_rd_en and b_rd_en high in the same cycle.
REQ-032 Bench SHALL cover: out_rd_en=0, sources offering 4 pairs -> exactly 2 pops, then rd_en low while S_FULL; then out_rd_en=1 for 2 cycles -> pairs 1 and 2 in order, and pops resume.
REQ-033 Bench SHALL cover: 100 pairs with values including -7, 0x7FFFFFFF and 0x80000000, out_rd_en=1 throughout -> one pair per cycle after the first, order and values exact against a scoreboard.
REQ-034 Bench SHALL cover: reset=0 for one edge while in S_FULL -> out_empty=1 the next cycle, and the 2 held pairs never appear on x/y.

Source files
------------

// File: rtl/vec3_join.sv
// vec3_join
//
// Joins two first-word-fall-through FIFOs of 3-element signed vectors into a
// single stream of (A,B) pairs. A pair is taken only when both sources have a
// word, so the two sides never drift apart. Joined pairs sit in a 2-entry
// in-order buffer whose head drives x/y straight from registers.
//
// Ports
//   clock      single clock; all state updates on the rising edge
//   reset      synchronous active-low reset
//   a[2:0]     head vector of FIFO A (valid while a_empty=0)
//   a_empty    FIFO A empty flag
//   a_rd_en    pop strobe to FIFO A
//   b[2:0]     head vector of FIFO B (valid while b_empty=0)
//   b_empty    FIFO B empty flag
//   b_rd_en    pop strobe to FIFO B (always equal to a_rd_en)
//   x[2:0]     A-half of the oldest held pair
//   y[2:0]     B-half of the oldest held pair
//   out_empty  high when no pair is held
//   out_rd_en  downstream pop of the head pair
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | no pair held; out_empty=1
// S_ONE   | one pair held in the head register
// S_FULL  | two pairs held; head is older, tail is newer
module vec3_join #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] a [2:0],
  input  logic                         a_empty,
  output logic                         a_rd_en,
  input  logic signed [DATA_WIDTH-1:0] b [2:0],
  input  logic                         b_empty,
  output logic                         b_rd_en,
  output logic signed [DATA_WIDTH-1:0] x [2:0],
  output logic signed [DATA_WIDTH-1:0] y [2:0],
  output logic                         out_empty,
  input  logic                         out_rd_en
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic push;
  logic pop;
  logic load_head_in;
  logic load_head_tail;
  logic load_tail_in;
  logic out_empty_q;

  logic signed [DATA_WIDTH-1:0] head_a [2:0];
  logic signed [DATA_WIDTH-1:0] head_b [2:0];
  logic signed [DATA_WIDTH-1:0] tail_a [2:0];
  logic signed [DATA_WIDTH-1:0] tail_b [2:0];

  // Pop decision looks only at state, never at out_rd_en, so S_FULL blocks
  // intake even in a cycle where the downstream is draining.
  assign push    = reset & ~a_empty & ~b_empty & (state != S_FULL);
  assign a_rd_en = push;
  assign b_rd_en = push;

  // Downstream pops on an empty buffer are dropped here.
  assign pop = out_rd_en & (state != S_EMPTY);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_EMPTY;
      out_empty_q <= 1'b1;
    end else begin
      state       <= state_next;
      out_empty_q <= (state_next == S_EMPTY);
    end
  end

  always_comb begin
    state_next     = state;
    load_head_in   = 1'b0;
    load_head_tail = 1'b0;
    load_tail_in   = 1'b0;
    case (state)
      S_EMPTY: begin
        if (push) begin
          state_next   = S_ONE;
          load_head_in = 1'b1;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          // head leaves as the new pair arrives; it becomes the head directly
          load_head_in = 1'b1;
        end else if (push) begin
          state_next   = S_FULL;
          load_tail_in = 1'b1;
        end else if (pop) begin
          state_next = S_EMPTY;
        end
      end
      S_FULL: begin
        // push is impossible here, only the drain path matters
        if (pop) begin
          state_next     = S_ONE;
          load_head_tail = 1'b1;
        end
      end
      default: begin
        state_next = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        head_a[i] <= '0;
        head_b[i] <= '0;
        tail_a[i] <= '0;
        tail_b[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (load_head_in) begin
          head_a[i] <= a[i];
          head_b[i] <= b[i];
        end else if (load_head_tail) begin
          head_a[i] <= tail_a[i];
          head_b[i] <= tail_b[i];
        end
        if (load_tail_in) begin
          tail_a[i] <= a[i];
          tail_b[i] <= b[i];
        end
      end
    end
  end

  assign x         = head_a;
  assign y         = head_b;
  assign out_empty = out_empty_q;

endmodule

// File: tb/tb_vec3_join.sv
module tb_vec3_join;

  typedef logic [2:0][31:0] vec_t;
  typedef struct packed {
    vec_t a;
    vec_t b;
  } pair_t;

  typedef struct packed {
    bit rst_n;
    bit ga;
    bit gb;
    bit ord;
    bit exp_rd;
    bit exp_oe;
  } row_t;

  logic clock;
  logic reset;
  logic signed [31:0] a [2:0];
  logic signed [31:0] b [2:0];
  logic signed [31:0] x [2:0];
  logic signed [31:0] y [2:0];
  logic a_empty, b_empty, a_rd_en, b_rd_en, out_empty, out_rd_en;

  vec3_join #(.DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .a(a), .a_empty(a_empty), .a_rd_en(a_rd_en),
    .b(b), .b_empty(b_empty), .b_rd_en(b_rd_en),
    .x(x), .y(y), .out_empty(out_empty), .out_rd_en(out_rd_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  vec_t  qa[$];
  vec_t  qb[$];
  pair_t sb[$];
  bit    model_valid = 0;
  bit    exp_rd;

  row_t tab [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit ga, input bit gb, input bit o);
    reset   = r;
    a_empty = !(ga && qa.size() > 0);
    b_empty = !(gb && qb.size() > 0);
    for (int i = 0; i < 3; i++) begin
      a[i] = (qa.size() > 0) ? qa[0][i] : '0;
      b[i] = (qb.size() > 0) ? qb[0][i] : '0;
    end
    out_rd_en = o;
    #1;
    exp_rd = reset && !a_empty && !b_empty && (sb.size() != 2);
  endtask

  task automatic check_model();
    chk("a_rd_en", {31'b0, a_rd_en}, {31'b0, exp_rd});
    chk("b_rd_en", {31'b0, b_rd_en}, {31'b0, exp_rd});
    if (model_valid) begin
      chk("out_empty", {31'b0, out_empty}, {31'b0, sb.size() == 0});
      if (sb.size() > 0) begin
        for (int i = 0; i < 3; i++) begin
          chk("x_head", x[i], sb[0].a[i]);
          chk("y_head", y[i], sb[0].b[i]);
        end
      end
    end
  endtask

  task automatic advance();
    pair_t p;
    if (!reset) begin
      sb.delete();
      model_valid = 1;
    end else begin
      if (out_rd_en && sb.size() > 0) void'(sb.pop_front());
      if (exp_rd) begin
        p.a = qa.pop_front();
        p.b = qb.pop_front();
        sb.push_back(p);
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [31:0] pick(input int k);
    case (k % 5)
      0:       return 32'hFFFF_FFF9;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t va, vb;
    int first, last, npop;

    // rst_n ga gb ord exp_rd exp_oe
    tab[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tab[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tab[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tab[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tab[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tab[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tab[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tab[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) begin
        va[i] = 32'(6 * k + i + 1);
        vb[i] = 32'(6 * k + i + 4);
      end
      qa.push_back(va);
      qb.push_back(vb);
    end

    // reset with both sources offering data
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_a_rd_en", {31'b0, a_rd_en}, 32'd0);
    chk("rst_b_rd_en", {31'b0, b_rd_en}, 32'd0);
    check_model();
    advance();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_out_empty", {31'b0, out_empty}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("rst_x", x[i], 32'd0);
      chk("rst_y", y[i], 32'd0);
    end
    check_model();
    advance();

    // one-sided availability, first join, fill to full, drain in order
    for (int r = 0; r < 14; r++) begin
      drive(tab[r].rst_n, tab[r].ga, tab[r].gb, tab[r].ord);
      chk($sformatf("tab%0d_a_rd_en", r), {31'b0, a_rd_en}, {31'b0, tab[r].exp_rd});
      chk($sformatf("tab%0d_b_rd_en", r), {31'b0, b_rd_en}, {31'b0, tab[r].exp_rd});
      chk($sformatf("tab%0d_out_empty", r), {31'b0, out_empty}, {31'b0, tab[r].exp_oe});
      if (r == 6) begin
        chk("first_pair_x0", x[0], 32'd1);
        chk("first_pair_x2", x[2], 32'd3);
        chk("first_pair_y0", y[0], 32'd4);
        chk("first_pair_y2", y[2], 32'd6);
      end
      check_model();
      advance();
    end

    // B nonempty with A empty must not pop either side
    va = '0; vb = '0;
    qa.push_back(va);
    qb.push_back(vb);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("b_only_rd", {31'b0, a_rd_en | b_rd_en}, 32'd0);
    check_model();
    advance();
    void'(qa.pop_front());
    void'(qb.pop_front());

    // 100 pairs streamed with the downstream always ready
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < 3; i++) begin
        va[i] = pick(k + i);
        vb[i] = pick(k + i + 2);
      end
      qa.push_back(va);
      qb.push_back(vb);
    end
    first = -1; last = -1; npop = 0;
    for (int c = 0; c < 400 && (qa.size() > 0 || sb.size() > 0); c++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      if (a_rd_en === 1'b1) begin
        if (first < 0) first = c;
        last = c;
        npop++;
      end
      check_model();
      advance();
    end
    chk("stream_drained", 32'(qa.size() + sb.size()), 32'd0);
    chk("stream_pops", 32'(npop), 32'd100);
    chk("stream_span", 32'(last - first), 32'd99);

    // reset while holding two pairs
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        va[i] = 32'h5500_0000 + 32'(16 * k + i);
        vb[i] = 32'hAA00_0000 + 32'(16 * k + i);
      end
      qa.push_back(va);
      qb.push_back(vb);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0); check_model(); advance();
    drive(1'b1, 1'b1, 1'b1, 1'b0); check_model(); advance();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("full_rd_blocked", {31'b0, a_rd_en}, 32'd0);
    chk("full_out_empty", {31'b0, out_empty}, 32'd0);
    check_model(); advance();
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    chk("midrst_rd", {31'b0, a_rd_en | b_rd_en}, 32'd0);
    check_model(); advance();
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    chk("midrst_out_empty", {31'b0, out_empty}, 32'd1);
    for (int i = 0; i < 3; i++) chk("midrst_x", x[i], 32'd0);
    check_model(); advance();
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      if (out_empty === 1'b0) begin
        chk("no_stale_x0", x[0], 32'h5500_0020);
        chk("no_stale_y0", y[0], 32'hAA00_0020);
      end
      check_model();
      advance();
    end
    chk("final_drained", 32'(qa.size() + sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
